// File: rtl/alu_bit_serial_seq.sv
// -----------------------------------------------------------------------------
// alu_bit_serial_seq
//
// Purpose:
//   Runs a full-width ALU operation on an external 1-bit ALU slice by feeding
//   it one operand bit pair per clock, LSB first, over WIDTH cycles. Shifts the
//   operands, recirculates the slice carry, collects the result bits, and for
//   SLT/SLTU spends one extra cycle driving the slice's set input with the
//   computed "less" bit.
//
// Optional feature:
//   ALU_SEQ_OVF_EN - when defined, adds overflow_o (signed overflow of the last
//   ADD/SUB, 0 for other ops). When undefined the port and logic are absent.
//
// Ports:
//   clk_i, rst_i          clock (rising edge), asynchronous active-high reset
//   start_i               operation request, sampled only in IDLE
//   op_i[3:0]             0000 ADD, 0001 AND, 0010 OR, 0011 XOR, 0100 SLTU,
//                         0101 SUB, 0110 SLT; any other code yields 0
//   a_i, b_i[WIDTH-1:0]   operands, latched when start is accepted
//   busy_o                high while bits are being processed (RUN, SET)
//   done_o                one-cycle pulse, result outputs valid
//   res_o, zero_o         assembled result and (res_o == 0), held until the
//                         next accepted start
//   carry_o               final carry-out for ADD/SUB, else 0
//   slice_a_o/b_o/c_o     bit, bit and carry fed to the slice
//   slice_sel_o[3:0]      slice operation select
//   slice_set_o           slice set input (SLT/SLTU result bit)
//   slice_inver_o         slice B-invert control
//   slice_res_i/c_i       slice result bit and carry-out
//   overflow_o            (ALU_SEQ_OVF_EN only) signed overflow of ADD/SUB
//   state_o[1:0]          current FSM state for observation
//                         (0 IDLE, 1 RUN, 2 SET, 3 DONE)
//
// Handshake:
//   start_i is accepted only on a clock edge where the FSM is in IDLE; start_i
//   in any other state has no effect. busy_o is high from the cycle after
//   acceptance until the result is ready; done_o then pulses for exactly one
//   cycle with res_o/zero_o/carry_o already valid in that cycle. The next
//   start can be accepted in the IDLE cycle that follows done_o.
// -----------------------------------------------------------------------------
module alu_bit_serial_seq #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 5
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             start_i,
   input  logic [3:0]       op_i,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   output logic             busy_o,
   output logic             done_o,
   output logic [WIDTH-1:0] res_o,
   output logic             zero_o,
   output logic             carry_o,
   output logic             slice_a_o,
   output logic             slice_b_o,
   output logic             slice_c_o,
   output logic [3:0]       slice_sel_o,
   output logic             slice_set_o,
   output logic             slice_inver_o,
   input  logic             slice_res_i,
   input  logic             slice_c_i,
`ifdef ALU_SEQ_OVF_EN
   output logic             overflow_o,
`endif
   output logic [1:0]       state_o
);

   // Operation codes
   localparam logic [3:0] OP_ADD  = 4'b0000;
   localparam logic [3:0] OP_AND  = 4'b0001;
   localparam logic [3:0] OP_OR   = 4'b0010;
   localparam logic [3:0] OP_XOR  = 4'b0011;
   localparam logic [3:0] OP_SLTU = 4'b0100;
   localparam logic [3:0] OP_SUB  = 4'b0101;
   localparam logic [3:0] OP_SLT  = 4'b0110;

   // Slice select used during the set cycle of SLT/SLTU
   localparam logic [3:0] SEL_SET = 4'b0110;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_SET  = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t state_q;
   state_t state_d;

   // Latched operation and shift registers
   logic [3:0]       op_q;
   logic [WIDTH-1:0] a_sh;
   logic [WIDTH-1:0] b_sh;
   logic [WIDTH-1:0] res_sh;
   logic [CNT_W-1:0] cnt_q;
   logic             cy_q;

   // MSB-stage snapshot used by SLT/SLTU
   logic             cin_msb_q;
   logic             cout_msb_q;
   logic             sum_msb_q;

   // Result registers
   logic [WIDTH-1:0] res_q;
   logic             zero_q;
   logic             carry_q;
   logic             ovf_q;

   // Decoded properties of the latched op
   logic             op_is_slt;
   logic             op_is_arith;
   logic             op_is_plain;
   logic             last_bit;
   logic             less;
   logic [WIDTH-1:0] fin_res;

   // Start-time decode: subtract-style ops begin with carry-in 1
   logic             start_inv;

   assign start_inv   = (op_i == OP_SUB) || (op_i == OP_SLT) || (op_i == OP_SLTU);
   assign op_is_slt   = (op_q == OP_SLT) || (op_q == OP_SLTU);
   assign op_is_arith = (op_q == OP_ADD) || (op_q == OP_SUB);
   assign op_is_plain = (op_q == OP_ADD) || (op_q == OP_AND) || (op_q == OP_OR) ||
                        (op_q == OP_XOR) || (op_q == OP_SUB);
   assign last_bit    = (cnt_q == CNT_LAST);

   // Signed less-than corrects the MSB sum for overflow (cin ^ cout at the
   // MSB); unsigned less-than is simply "no carry out of a + ~b + 1".
   assign less = (op_q == OP_SLT) ? (sum_msb_q ^ (cin_msb_q ^ cout_msb_q))
                                  : ~cout_msb_q;

   // Result presented on the final RUN edge: shift register plus the bit the
   // slice is producing right now. Unknown ops collapse to zero.
   always_comb begin
      fin_res = '0;
      if (op_is_plain) begin
         fin_res = {slice_res_i, res_sh[WIDTH-1:1]};
      end
   end

   // ---------------------------------------------------------------------------
   // FSM state register
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // ---------------------------------------------------------------------------
   // FSM next-state and slice/handshake outputs
   // ---------------------------------------------------------------------------
   always_comb begin
      state_d       = state_q;
      busy_o        = 1'b0;
      done_o        = 1'b0;
      slice_a_o     = 1'b0;
      slice_b_o     = 1'b0;
      slice_c_o     = 1'b0;
      slice_sel_o   = 4'b0000;
      slice_set_o   = 1'b0;
      slice_inver_o = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (start_i) begin
               state_d = S_RUN;
            end
         end

         S_RUN: begin
            busy_o        = 1'b1;
            slice_a_o     = a_sh[0];
            slice_b_o     = b_sh[0];
            slice_c_o     = cy_q;
            slice_inver_o = (op_q == OP_SUB) || op_is_slt;
            // Comparisons run the slice as a subtractor
            slice_sel_o   = op_is_slt ? OP_SUB : op_q;
            if (last_bit) begin
               state_d = op_is_slt ? S_SET : S_DONE;
            end
         end

         S_SET: begin
            busy_o      = 1'b1;
            slice_sel_o = SEL_SET;
            slice_set_o = less;
            state_d     = S_DONE;
         end

         S_DONE: begin
            done_o  = 1'b1;
            state_d = S_IDLE;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // ---------------------------------------------------------------------------
   // Datapath: operand shifting, carry recirculation, result assembly
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         op_q       <= 4'b0000;
         a_sh       <= '0;
         b_sh       <= '0;
         res_sh     <= '0;
         cnt_q      <= '0;
         cy_q       <= 1'b0;
         cin_msb_q  <= 1'b0;
         cout_msb_q <= 1'b0;
         sum_msb_q  <= 1'b0;
         res_q      <= '0;
         zero_q     <= 1'b0;
         carry_q    <= 1'b0;
         ovf_q      <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (start_i) begin
                  op_q   <= op_i;
                  a_sh   <= a_i;
                  b_sh   <= b_i;
                  res_sh <= '0;
                  cnt_q  <= '0;
                  cy_q   <= start_inv;
               end
            end

            S_RUN: begin
               res_sh <= {slice_res_i, res_sh[WIDTH-1:1]};
               cy_q   <= slice_c_i;
               a_sh   <= a_sh >> 1;
               b_sh   <= b_sh >> 1;
               cnt_q  <= cnt_q + CNT_W'(1);
               if (last_bit) begin
                  cin_msb_q  <= cy_q;
                  cout_msb_q <= slice_c_i;
                  sum_msb_q  <= slice_res_i;
                  // Non-compare ops finish here, so the result is visible in
                  // the same cycle done_o is asserted.
                  if (!op_is_slt) begin
                     res_q   <= fin_res;
                     zero_q  <= (fin_res == '0);
                     carry_q <= op_is_arith ? slice_c_i : 1'b0;
                     ovf_q   <= op_is_arith ? (cy_q ^ slice_c_i) : 1'b0;
                  end
               end
            end

            S_SET: begin
               res_q   <= {{(WIDTH-1){1'b0}}, slice_res_i};
               zero_q  <= ~slice_res_i;
               carry_q <= 1'b0;
               ovf_q   <= 1'b0;
            end

            default: begin
            end
         endcase
      end
   end

   assign res_o   = res_q;
   assign zero_o  = zero_q;
   assign carry_o = carry_q;
   assign state_o = state_q;

`ifdef ALU_SEQ_OVF_EN
   assign overflow_o = ovf_q;
`else
   // Overflow is only exported when the feature is enabled
   logic unused_ovf;
   assign unused_ovf = ovf_q;
`endif

endmodule
